// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : rf_wb_arbiter_if
// Description: Writeback requester bus, decode allocation/flush, scoreboard
//              and register-file write port grouped for rf_wb_arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic               flush;
  logic [2**AW-1:0]   busy;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  modport slave (
    input  req_valid, req_addr, req_data, alloc_en, alloc_addr, flush,
    output req_ready, busy, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, alloc_en, alloc_addr, flush,
    input  req_ready, busy, rf_we, rf_waddr, rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rf_wb_arbiter
// Description: Round-robin arbiter sharing the RF write port among NREQ
//              writeback sources, with a pending-write busy scoreboard.
// Revision   : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  wire logic           clk,
  input  wire logic           rst,
  rf_wb_arbiter_if.slave      bus
);
  localparam int              PW     = (NREQ > 2) ? 2 : 1;
  localparam int              NREG   = 2**AW;
  localparam logic [PW-1:0]   c_LAST = PW'(NREQ-1);

  logic [PW-1:0]   r_rr_ptr;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;

  logic [NREQ-1:0] w_grant;
  logic            w_found;
  logic [PW-1:0]   w_gidx;
  logic            w_accept;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic [NREG-1:0] w_busy_nxt;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_grant[idx] = 1'b1;
        w_gidx       = idx[PW-1:0];
        w_found      = 1'b1;
      end
    end
  end

  assign w_accept      = w_found & ~rst;
  assign bus.req_ready = rst ? '0 : w_grant;
  assign w_sel_addr    = bus.req_addr[int'(w_gidx)*AW +: AW];
  assign w_sel_data    = bus.req_data[int'(w_gidx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
      // r0 writes are consumed but never reach the RF.
      r_we     <= (w_sel_addr != '0);
      r_waddr  <= w_sel_addr;
      r_wdata  <= w_sel_data;
    end else begin
      r_we     <= 1'b0;
    end
  end

  // Set is applied after clear so a new producer outlives the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_waddr] = 1'b0;
    if (bus.alloc_en && (bus.alloc_addr != '0)) w_busy_nxt[bus.alloc_addr] = 1'b1;
    if (bus.flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign bus.busy     = r_busy;
  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
endmodule
`default_nettype wire
